// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI mode-0 master.
package spi_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Header every accepted rx frame must carry in its top 32 bits
    localparam logic [31:0] MSGID_DEFAULT = 32'h74697277;

    // Bits needed to hold values 0..value-1 (never less than 1)
    function automatic int unsigned clog2(input logic [63:0] value);
        int unsigned width;
        width = 0;
        while (((64'd1 << width) < value) && (width < 64)) begin
            width++;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period generator: while run is high, SCK toggles every CLK_DIV
// clocks starting from a full low half-period; rise/fall are 1-clk strobes
// in the first clock after the corresponding SCK edge.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int unsigned         DIV_W    = clog2(64'(CLK_DIV));
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Divider restarts whenever run drops, so every SHIFT entry begins cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!run) begin
                div_cnt <= '0;
                sck     <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sck     <= ~sck;
                rise    <= ~sck;
                fall    <= sck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex BUFFER_SIZE-bit frame per start, MSB
// first, rx frame accepted only when its top 32 bits match MSGID, with a
// link timeout flag.
// Optional feature: define SPI_MASTER_AUTOPOLL_EN to add a free-running
// POLL_PERIOD timer that launches frames on its own (ORed with start).
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 64,
    parameter logic [31:0] MSGID       = MSGID_DEFAULT,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CS_SETUP    = 4,
    parameter int unsigned CS_GAP      = 8,
    parameter int unsigned TIMEOUT     = 4800000,
    parameter int unsigned POLL_PERIOD = 48000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_error,
    output logic                   busy,
    output logic                   done,
    output logic                   pkg_timeout,
    output logic                   SPI_SCK,
    output logic                   SPI_SSEL,
    output logic                   SPI_MOSI,
    input  logic                   SPI_MISO
);

    localparam int unsigned PH_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int unsigned PH_W   = clog2(64'(PH_MAX));
    localparam int unsigned BIT_W  = clog2(64'(BUFFER_SIZE) + 64'd1);
    localparam int unsigned TO_W   = clog2(64'(TIMEOUT) + 64'd1);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BUFFER_SIZE);
    localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT);

    // Reject parameter sets the frame timing cannot support
    if ((BUFFER_SIZE < 33) || (CLK_DIV < 2) || (CS_SETUP < 1) || (CS_GAP < 1) ||
        (POLL_PERIOD < 1)) begin : g_bad_params
        $error("spi_master: unsupported parameter set");
    end

    state_t                 state;
    logic [PH_W-1:0]        phase_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BUFFER_SIZE-1:0] tx_shift;
    logic [BUFFER_SIZE-1:0] rx_shift;
    logic [TO_W-1:0]        to_cnt;
    logic                   miso_meta;
    logic                   miso_sync;
    logic                   sck_run;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   header_ok;
    logic                   accept;
    logic                   launch_req;

    assign sck_run   = (state == ST_SHIFT);
    assign header_ok = (rx_shift[BUFFER_SIZE-1 -: 32] == MSGID);
    assign accept    = (state == ST_HOLD) && (phase_cnt == SETUP_LAST) && header_ok;

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (sck_run),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .sck   (SPI_SCK)
    );

`ifdef SPI_MASTER_AUTOPOLL_EN
    localparam int unsigned       POLL_W    = clog2(64'(POLL_PERIOD));
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

    logic [POLL_W-1:0] poll_cnt;
    logic              poll_tick;
    logic              poll_pending;

    assign poll_tick  = (poll_cnt == POLL_LAST);
    assign launch_req = start | poll_tick | poll_pending;

    // Free-running poll timer; a tick landing while busy waits (once) for IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            poll_cnt <= poll_tick ? '0 : poll_cnt + 1'b1;
            if (state == ST_IDLE) begin
                poll_pending <= 1'b0;
            end else if (poll_tick) begin
                poll_pending <= 1'b1;
            end
        end
    end
`else
    assign launch_req = start;
`endif

    // Bring MISO into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= SPI_MISO;
            miso_sync <= miso_meta;
        end
    end

    // Frame sequencer: chip-select framing, bit shifting and rx acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            SPI_SSEL  <= 1'b1;
            SPI_MOSI  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (launch_req) begin
                        tx_shift  <= tx_data;
                        SPI_MOSI  <= tx_data[BUFFER_SIZE-1];
                        SPI_SSEL  <= 1'b0;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        phase_cnt <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        phase_cnt <= '0;
                        state     <= ST_SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx_shift <= {rx_shift[BUFFER_SIZE-2:0], miso_sync};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    if (sck_fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            phase_cnt <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            // Rotate keeps every bit live; only the MSB is ever driven
                            tx_shift <= {tx_shift[BUFFER_SIZE-2:0], tx_shift[BUFFER_SIZE-1]};
                            SPI_MOSI <= tx_shift[BUFFER_SIZE-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_cnt == SETUP_LAST) begin
                        phase_cnt <= '0;
                        SPI_SSEL  <= 1'b1;
                        SPI_MOSI  <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_GAP;
                        if (header_ok) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating link timeout; an accepted frame clears it in the rx_valid cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            pkg_timeout <= 1'b0;
        end else if (accept) begin
            to_cnt      <= '0;
            pkg_timeout <= 1'b0;
        end else if (to_cnt < TO_LIMIT) begin
            to_cnt      <= to_cnt + 1'b1;
            pkg_timeout <= ((to_cnt + 1'b1) >= TO_LIMIT);
        end else begin
            pkg_timeout <= 1'b1;
        end
    end

endmodule
